// File: rtl/npu_ctrl_pkg.sv
// npu_ctrl_pkg: shared types for the NPU loop sequencer.
//   state_t     - sequencer state encoding (3 bits)
//   ctrl_t      - Moore control-output vector
//   ctrl_decode - state -> control outputs
//   *_W_DEF     - default counter widths
package npu_ctrl_pkg;

    localparam int IFM_W_DEF  = 8;
    localparam int OFM_W_DEF  = 8;
    localparam int TILE_W_DEF = 6;
    localparam int PH_W_DEF   = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HMODE = 3'd1,
        VMODE = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic en_npu;
        logic en_hmode;
        logic en_vmode;
        logic ldh_v_n;
        logic en_p;
        logic wr_pipe;
        logic wr_mem;
        logic busy;
        logic done;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c          = '0;
        c.en_npu   = (s == HMODE) || (s == VMODE);
        c.en_hmode = (s == HMODE);
        c.en_vmode = (s == VMODE);
        c.ldh_v_n  = (s == VMODE);
        c.en_p     = (s == DRAIN) || (s == WRITE);
        c.wr_pipe  = c.en_p;
        c.wr_mem   = (s == WRITE);
        c.busy     = (s != IDLE);
        c.done     = (s == DONE);
        return c;
    endfunction

endpackage

// File: rtl/npu_loop_fsm_loop_cnt.sv
// loop_cnt: N-1 encoded loop counter.
//   clr    - synchronous clear (priority over en)
//   en     - advance; wraps to 0 on the cycle cnt == tc_val
//   tc_val - terminal value (iterations minus 1)
//   cnt    - current count
//   tc     - cnt == tc_val
module loop_cnt
    import npu_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc  = (cnt_q == tc_val);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tc ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge ck) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/npu_loop_fsm.sv
// npu_loop_fsm: NPU job sequencer with internal loop counters.
//   Loop nest outer->inner: tilev, tileh, ofmaps; ifmaps iterate inside
//   each output tile as HMODE/VMODE pairs, followed by DRAIN and WRITE.
//   Inputs : ck, rst (sync, high), start, abort, cfg_* (N-1 encoded counts
//            and phase lengths, latched at start), wr_ready.
//   Outputs: ctrl_* mode enables / write-back request (Moore), busy, done,
//            and the loop indices for the address generators.
module npu_loop_fsm
    import npu_ctrl_pkg::*;
#(
    parameter int IFM_W  = IFM_W_DEF,
    parameter int OFM_W  = OFM_W_DEF,
    parameter int TILE_W = TILE_W_DEF,
    parameter int PH_W   = PH_W_DEF
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [IFM_W-1:0]  cfg_n_ifmaps,
    input  logic [OFM_W-1:0]  cfg_n_ofmaps,
    input  logic [TILE_W-1:0] cfg_n_tileh,
    input  logic [TILE_W-1:0] cfg_n_tilev,
    input  logic [PH_W-1:0]   cfg_h_len,
    input  logic [PH_W-1:0]   cfg_v_len,
    input  logic [PH_W-1:0]   cfg_res_len,
    input  logic              wr_ready,
    output logic              ctrl_en_npu,
    output logic              ctrl_en_hmode,
    output logic              ctrl_en_vmode,
    output logic              ctrl_ldh_v_n,
    output logic              ctrl_en_p,
    output logic              ctrl_wr_pipe,
    output logic              ctrl_wr_mem,
    output logic              busy,
    output logic              done,
    output logic [IFM_W-1:0]  ifm_idx,
    output logic [OFM_W-1:0]  ofm_idx,
    output logic [TILE_W-1:0] tileh_idx,
    output logic [TILE_W-1:0] tilev_idx
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

    // shadow config, only updated when a job is accepted
    logic [IFM_W-1:0]  n_ifm_q,   n_ifm_d;
    logic [OFM_W-1:0]  n_ofm_q,   n_ofm_d;
    logic [TILE_W-1:0] n_tileh_q, n_tileh_d;
    logic [TILE_W-1:0] n_tilev_q, n_tilev_d;
    logic [PH_W-1:0]   h_len_q,   h_len_d;
    logic [PH_W-1:0]   v_len_q,   v_len_d;
    logic [PH_W-1:0]   res_len_q, res_len_d;

    logic            accept, kill, xfer, cnt_clr, all_tc;
    logic            ph_en, ph_tc, ifm_tc, ofm_tc, tileh_tc, tilev_tc;
    logic [PH_W-1:0] ph_cnt, ph_tc_val;

    assign accept  = (state_q == IDLE) && start && !abort;
    assign kill    = abort && (state_q != IDLE);
    assign xfer    = (state_q == WRITE) && wr_ready;
    // DONE clears so indices read 0 once back in IDLE
    assign cnt_clr = kill || (state_q == IDLE) || (state_q == DONE);
    // final transfer leaves every index parked at its terminal value
    assign all_tc  = ofm_tc && tileh_tc && tilev_tc;

    assign ph_en = (state_q == HMODE) || (state_q == VMODE) || (state_q == DRAIN);

    always_comb begin
        ph_tc_val = res_len_q;
        case (state_q)
            HMODE:   ph_tc_val = h_len_q;
            VMODE:   ph_tc_val = v_len_q;
            default: ph_tc_val = res_len_q;
        endcase
    end

    loop_cnt #(.W(PH_W)) u_ph (
        .ck(ck), .rst(rst), .clr(cnt_clr), .en(ph_en),
        .tc_val(ph_tc_val), .cnt(ph_cnt), .tc(ph_tc)
    );

    loop_cnt #(.W(IFM_W)) u_ifm (
        .ck(ck), .rst(rst), .clr(cnt_clr), .en((state_q == VMODE) && ph_tc),
        .tc_val(n_ifm_q), .cnt(ifm_idx), .tc(ifm_tc)
    );

    loop_cnt #(.W(OFM_W)) u_ofm (
        .ck(ck), .rst(rst), .clr(cnt_clr), .en(xfer && !all_tc),
        .tc_val(n_ofm_q), .cnt(ofm_idx), .tc(ofm_tc)
    );

    loop_cnt #(.W(TILE_W)) u_tileh (
        .ck(ck), .rst(rst), .clr(cnt_clr), .en(xfer && ofm_tc && !all_tc),
        .tc_val(n_tileh_q), .cnt(tileh_idx), .tc(tileh_tc)
    );

    loop_cnt #(.W(TILE_W)) u_tilev (
        .ck(ck), .rst(rst), .clr(cnt_clr), .en(xfer && ofm_tc && tileh_tc && !all_tc),
        .tc_val(n_tilev_q), .cnt(tilev_idx), .tc(tilev_tc)
    );

    always_comb begin
        n_ifm_d   = n_ifm_q;
        n_ofm_d   = n_ofm_q;
        n_tileh_d = n_tileh_q;
        n_tilev_d = n_tilev_q;
        h_len_d   = h_len_q;
        v_len_d   = v_len_q;
        res_len_d = res_len_q;
        if (accept) begin
            n_ifm_d   = cfg_n_ifmaps;
            n_ofm_d   = cfg_n_ofmaps;
            n_tileh_d = cfg_n_tileh;
            n_tilev_d = cfg_n_tilev;
            h_len_d   = cfg_h_len;
            v_len_d   = cfg_v_len;
            res_len_d = cfg_res_len;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = HMODE;
            HMODE: if (ph_tc)  state_d = VMODE;
            VMODE: if (ph_tc)  state_d = ifm_tc ? DRAIN : HMODE;
            DRAIN: if (ph_tc)  state_d = WRITE;
            WRITE: if (xfer)   state_d = all_tc ? DONE : HMODE;
            DONE:              state_d = IDLE;
            default:           state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= IDLE;
            n_ifm_q   <= '0;
            n_ofm_q   <= '0;
            n_tileh_q <= '0;
            n_tilev_q <= '0;
            h_len_q   <= '0;
            v_len_q   <= '0;
            res_len_q <= '0;
        end else begin
            state_q   <= state_d;
            n_ifm_q   <= n_ifm_d;
            n_ofm_q   <= n_ofm_d;
            n_tileh_q <= n_tileh_d;
            n_tilev_q <= n_tilev_d;
            h_len_q   <= h_len_d;
            v_len_q   <= v_len_d;
            res_len_q <= res_len_d;
        end
    end

    assign ctrl          = ctrl_decode(state_q);
    assign ctrl_en_npu   = ctrl.en_npu;
    assign ctrl_en_hmode = ctrl.en_hmode;
    assign ctrl_en_vmode = ctrl.en_vmode;
    assign ctrl_ldh_v_n  = ctrl.ldh_v_n;
    assign ctrl_en_p     = ctrl.en_p;
    assign ctrl_wr_pipe  = ctrl.wr_pipe;
    assign ctrl_wr_mem   = ctrl.wr_mem;
    assign busy          = ctrl.busy;
    assign done          = ctrl.done;

endmodule
